// File: rtl/fdiv_gs_seq.sv
// Goldschmidt floating-point divider with its own iteration sequencer and start/done handshake.
// Normal operands take 2*ITER+4 cycles and special operands take 2. start is ignored while busy.
module fdiv_gs_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ITER  = 5,
  parameter int GUARD = 6,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] n,
  input  logic [W-1:0] d,
  input  logic [1:0]   rm,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [4:0]   flags
);
  localparam int FW   = MAN_W + GUARD;
  localparam int DW   = FW + 2;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = MAN_W + 1;
  localparam int RW   = 2 * MW + 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [DW-1:0]        TWO    = {2'b10, {FW{1'b0}}};
  localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ITER_MUL, S_ITER_K, S_NORM, S_ROUND, S_OUT
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   n_r, d_r;
  logic [1:0]     rm_r;
  logic [EW-1:0]  exp_r;
  logic [DW-1:0]  nq, dq, kq;
  logic [CW-1:0]  cnt;
  logic           sh;
  logic [W-1:0]   res;
  logic [4:0]     res_fl;

  logic [EXP_W-1:0] en, ed;
  logic [MAN_W-1:0] fn, fd;
  logic [MW-1:0]    nm, dm;
  logic             sgn_c, n_zero, d_zero, n_inf, d_inf, n_nan, d_nan, special, n_lt;
  logic [W-1:0]     inf_val, sp_res;
  logic [4:0]       sp_fl;

  // Fixed-point multiply with FW fraction bits, truncated back to datapath width.
  function automatic logic [DW-1:0] fmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return DW'(({{DW{1'b0}}, a} * {{DW{1'b0}}, b}) >> FW);
  endfunction

  assign en      = n_r[W-2:MAN_W];
  assign ed      = d_r[W-2:MAN_W];
  assign fn      = n_r[MAN_W-1:0];
  assign fd      = d_r[MAN_W-1:0];
  assign nm      = {1'b1, fn};
  assign dm      = {1'b1, fd};
  assign sgn_c   = n_r[W-1] ^ d_r[W-1];
  assign n_zero  = (en == '0);
  assign d_zero  = (ed == '0);
  assign n_inf   = (en == '1) && (fn == '0);
  assign d_inf   = (ed == '1) && (fd == '0);
  assign n_nan   = (en == '1) && (fn != '0);
  assign d_nan   = (ed == '1) && (fd != '0);
  assign special = n_zero || d_zero || (en == '1) || (ed == '1);
  assign n_lt    = (nm < dm);
  assign inf_val = {sgn_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign busy    = (state != S_IDLE);

  always_comb begin
    sp_res = {sgn_c, {(W-1){1'b0}}};
    sp_fl  = 5'b00000;
    if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) begin
      sp_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      sp_fl  = 5'b10000;
    end else if (n_inf) begin
      sp_res = inf_val;
    end else if (d_zero) begin
      sp_res = inf_val;
      sp_fl  = 5'b01000;
    end
  end

  // Rounding: the iterated quotient is trusted to +-1 ulp; the exact remainder fixes it up.
  logic [MW:0]             qt, qc, sum;
  logic [RW-1:0]           num, qx, dx;
  logic signed [RW-1:0]    rem, rc, dms;
  logic                    gt, eq, nz, up, carry, to_inf;
  logic [MAN_W-1:0]        frac;
  logic [EW-1:0]           ef;
  logic [W-1:0]            rnd_res;
  logic [4:0]              rnd_fl;

  always_comb begin
    qt  = nq[DW-1:GUARD];
    num = RW'(nm) << (sh ? MW : MAN_W);
    qx  = RW'(qt);
    dx  = RW'(dm);
    dms = $signed(dx);
    rem = $signed(num - qx * dx);
    qc  = qt;
    rc  = rem;
    if (rem[RW-1]) begin
      qc = qt - (MW+1)'(1);
      rc = rem + dms;
    end else if (rem >= dms) begin
      qc = qt + (MW+1)'(1);
      rc = rem - dms;
    end
    gt = (rc <<< 1) > dms;
    eq = (rc <<< 1) == dms;
    nz = (rc != '0);
    case (rm_r)
      2'b00:   up = gt || (eq && qc[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = sgn_c && nz;
      default: up = !sgn_c && nz;
    endcase
    sum    = qc + (MW+1)'(up);
    carry  = sum[MW];
    frac   = carry ? sum[MW-1:1] : sum[MAN_W-1:0];
    ef     = exp_r + EW'(carry);
    to_inf = (rm_r == 2'b00) || (rm_r == 2'b10 && sgn_c) || (rm_r == 2'b11 && !sgn_c);
    rnd_res = {sgn_c, ef[EXP_W-1:0], frac};
    rnd_fl  = {4'b0000, nz};
    if ($signed(ef) >= EMAX_E) begin
      rnd_res = to_inf ? inf_val : {sgn_c, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      rnd_fl  = 5'b00101;
    end else if (ef[EW-1] || ef == '0) begin
      rnd_res = {sgn_c, {(W-1){1'b0}}};
      rnd_fl  = 5'b00011;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_UNPACK;
      S_UNPACK:   state_nxt = special ? S_OUT : S_ITER_MUL;
      S_ITER_MUL: state_nxt = S_ITER_K;
      S_ITER_K:   state_nxt = (cnt == '0) ? S_NORM : S_ITER_MUL;
      S_NORM:     state_nxt = S_ROUND;
      S_ROUND:    state_nxt = S_OUT;
      S_OUT:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_r <= '0; d_r <= '0; rm_r <= '0; exp_r <= '0;
      nq <= '0; dq <= '0; kq <= '0; cnt <= '0; sh <= 1'b0;
      res <= '0; res_fl <= '0; q <= '0; flags <= '0; done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          n_r  <= n;
          d_r  <= d;
          rm_r <= rm;
        end
        S_UNPACK: begin
          exp_r  <= EW'(en) - EW'(ed) + EW'(BIAS);
          nq     <= DW'(nm) << (GUARD - 1);
          dq     <= DW'(dm) << (GUARD - 1);
          kq     <= TWO - (DW'(dm) << (GUARD - 1));
          cnt    <= CW'(ITER - 1);
          res    <= sp_res;
          res_fl <= sp_fl;
        end
        S_ITER_MUL: begin
          nq <= fmul(nq, kq);
          dq <= fmul(dq, kq);
        end
        S_ITER_K: begin
          kq  <= TWO - dq;
          cnt <= cnt - CW'(1);
        end
        S_NORM: begin
          sh <= n_lt;
          if (n_lt) begin
            nq    <= nq << 1;
            exp_r <= exp_r - EW'(1);
          end
        end
        S_ROUND: begin
          res    <= rnd_res;
          res_fl <= rnd_fl;
        end
        default: ;
      endcase
      done <= (state == S_OUT);
      if (state == S_OUT) begin
        q     <= res;
        flags <= res_fl;
      end
    end
  end
endmodule

// File: tb/tb_fdiv_gs_seq.sv
// Bench for fdiv_gs_seq: the driver queues hand-computed results, a done monitor checks
// quotient, flags and latency against the queue.
`timescale 1ns/1ps
module tb_fdiv_gs_seq;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] n, d, q;
  logic [1:0]  rm;
  logic        busy, done;
  logic [4:0]  flags;

  fdiv_gs_seq dut (
    .clk(clk), .reset(reset), .start(start), .n(n), .d(d), .rm(rm),
    .busy(busy), .done(done), .q(q), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [4:0]  fl;
    int          lat;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   vid = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic busy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: records acceptance cycles from busy rising, checks each done against the queue.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (reset) begin
      busy_q = 1'b0;
    end else begin
      if (busy && !busy_q) acc_q.push_back(cyc);
      busy_q = busy;
      if (done) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 with q=%h, expected no pending operation", q);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk($sformatf("q#%0d", e.id), q, e.q);
          chk($sformatf("flags#%0d", e.id), 32'(flags), 32'(e.fl));
          chk($sformatf("latency#%0d", e.id), 32'(cyc - a), 32'(e.lat));
          chk($sformatf("busy_at_done#%0d", e.id), 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] eq, input logic [4:0] ef, input int lat);
    exp_t e;
    e.q = eq; e.fl = ef; e.lat = lat; e.id = vid;
    vid++;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] r,
                       input logic [31:0] eq, input logic [4:0] ef, input int lat);
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected 0", t);
    end
    push_exp(eq, ef, lat);
    n = a; d = b; rm = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; n = '0; d = '0; rm = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1.5/1.25 under each rounding mode
    issue(32'h3FC00000, 32'h3FA00000, 2'b00, 32'h3F99999A, 5'b00001, 14);
    issue(32'h3FC00000, 32'h3FA00000, 2'b01, 32'h3F999999, 5'b00001, 14);
    issue(32'h3FC00000, 32'h3FA00000, 2'b11, 32'h3F99999A, 5'b00001, 14);
    issue(32'h3FC00000, 32'h3FA00000, 2'b10, 32'h3F999999, 5'b00001, 14);
    // exact quotients and normalisation shift
    issue(32'h40C00000, 32'h40400000, 2'b00, 32'h40000000, 5'b00000, 14);
    issue(32'hC0C00000, 32'h40400000, 2'b00, 32'hC0000000, 5'b00000, 14);
    issue(32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 5'b00001, 14);
    issue(32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 5'b00001, 14);
    issue(32'hBF800000, 32'h40400000, 2'b10, 32'hBEAAAAAB, 5'b00001, 14);
    issue(32'hBF800000, 32'h40400000, 2'b11, 32'hBEAAAAAA, 5'b00001, 14);
    // special operands
    issue(32'h3F800000, 32'h00000000, 2'b00, 32'h7F800000, 5'b01000, 2);
    issue(32'hBF800000, 32'h00000000, 2'b00, 32'hFF800000, 5'b01000, 2);
    issue(32'h00000000, 32'h00000000, 2'b00, 32'h7FC00000, 5'b10000, 2);
    issue(32'h7F800000, 32'h7F800000, 2'b00, 32'h7FC00000, 5'b10000, 2);
    issue(32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, 5'b10000, 2);
    issue(32'h7F800000, 32'h3F800000, 2'b00, 32'h7F800000, 5'b00000, 2);
    issue(32'h3F800000, 32'hFF800000, 2'b00, 32'h80000000, 5'b00000, 2);
    issue(32'h80000000, 32'h3F800000, 2'b00, 32'h80000000, 5'b00000, 2);
    issue(32'h00400000, 32'h3F800000, 2'b00, 32'h00000000, 5'b00000, 2);
    issue(32'h3F800000, 32'h00400000, 2'b00, 32'h7F800000, 5'b01000, 2);
    // overflow and underflow
    issue(32'h7F000000, 32'h3E800000, 2'b00, 32'h7F800000, 5'b00101, 14);
    issue(32'h7F000000, 32'h3E800000, 2'b01, 32'h7F7FFFFF, 5'b00101, 14);
    issue(32'h7F000000, 32'h3E800000, 2'b10, 32'h7F7FFFFF, 5'b00101, 14);
    issue(32'h7F000000, 32'h3E800000, 2'b11, 32'h7F800000, 5'b00101, 14);
    issue(32'hFF000000, 32'h3E800000, 2'b10, 32'hFF800000, 5'b00101, 14);
    issue(32'hFF000000, 32'h3E800000, 2'b11, 32'hFF7FFFFF, 5'b00101, 14);
    issue(32'h00800000, 32'h42000000, 2'b00, 32'h00000000, 5'b00011, 14);
    issue(32'h80800000, 32'h42000000, 2'b00, 32'h80000000, 5'b00011, 14);
    drain();

    // start held high: one operation, the next accepted right after done
    push_exp(32'h40000000, 5'b00000, 14);
    n = 32'h40C00000; d = 32'h40400000; rm = 2'b00; start = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 40);
    chk("held_start_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("reaccept_busy", 32'(busy), 32'd1);
    push_exp(32'h40000000, 5'b00000, 14);
    start = 1'b0;
    drain();

    // reset in the middle of an operation, after a result with nonzero flags
    issue(32'h3FC00000, 32'h3FA00000, 2'b00, 32'h3F99999A, 5'b00001, 14);
    drain();
    n = 32'h40C00000; d = 32'h40400000; rm = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_q", q, 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    acc_q.delete();
    repeat (20) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);

    issue(32'h40C00000, 32'h40400000, 2'b00, 32'h40000000, 5'b00000, 14);
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
